fifo_word_packer: RTL and testbench
===================================

# fifo_word_packer

Read-side consumer for the 8-bit single-clock FIFO. Drains bytes through the FIFO's get/data_out/empty interface and packs four consecutive bytes, little-endian, into a 32-bit word. Each word is presented on a valid/ready output port. A flush request emits a partial word with a byte-enable mask, so the block sits between the byte FIFO and any 32-bit downstream sink.

## Interface
- DATA_W, 8, FIFO byte width
- LANES, 4, bytes per output word; must be a power of two, at least 2
- WCNT_W, 16, width of the emitted-word counter

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset; sampled on the clk rising edge
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after fifo_get is sampled high
- fifo_get  out  1  FIFO read strobe; one byte per cycle sampled high
- flush  in  1  single-cycle pulse; emit the current partial word
- word_data  out  DATA_W*LANES  packed word; lane 0 is bits [7:0] and holds the first byte read
- word_be  out  LANES  per-lane byte enable
- word_last  out  1  word produced by a flush
- word_valid  out  1  word available
- word_ready  in  1  sink accepts the word
- words_out  out  WCNT_W  count of accepted words; wraps modulo 2^WCNT_W

## Operation
- States:
  - FILL: issue reads and capture bytes.
  - OUT: hold the word until it is accepted.
- Registers:
  - issued: gets issued for the current word, 0..LANES.
  - idx: bytes captured, 0..LANES.
  - pend: a read is in flight.
  - flush_req: a flush is latched.
- fifo_get = FILL && !fifo_empty && issued < LANES && !flush_req.
  - Combinational from registered state and fifo_empty only.
  - No path from word_ready.
- Each cycle fifo_get=1: issued += 1 and pend <= 1. Otherwise pend <= 0.
- Each cycle pend=1: fifo_data is written into lane idx, word_be[idx] <= 1, idx += 1.
- FILL -> OUT when idx reaches LANES (the capture cycle of the last byte). On entry, word_last <= 0 and word_valid <= 1.
- flush in FILL sets flush_req. A flush during OUT is ignored.
- flush_req with pend=0:
  - idx > 0: go to OUT with word_last=1 and word_be = captured lanes. Uncaptured lanes of word_data are 0.
  - idx = 0: clear flush_req and emit nothing.
- A flush arriving while a read is in flight waits for that byte, and the byte is included in the flushed word.
- OUT, word_valid && word_ready: words_out += 1; clear issued, idx, word_be, word_data, word_last and flush_req; word_valid <= 0; return to FILL.
- word_data, word_be and word_last are stable while word_valid=1 and word_ready=0.
- fifo_empty rising mid-word stalls the gets. The partial word is kept indefinitely until more bytes arrive or a flush.
- Reset, mid-operation or otherwise: any in-flight byte is discarded.

## Timing
- Reset values:
  - fifo_get=0, word_valid=0, word_data=0, word_be=0, word_last=0, words_out=0.
  - State FILL; issued=idx=0; pend=0; flush_req=0.
- Latency, FIFO non-empty: gets on cycles 0..3, captures on cycles 1..4, word_valid high from cycle 5.
- Peak throughput is one word per LANES+1 cycles plus one handshake cycle. Fill of the next word starts the cycle after acceptance.
- Flush: word_valid rises 1 cycle after flush is sampled when pend=0, or 2 cycles after when pend=1.
- A flush sampled together with the final byte's capture still produces a full word with word_last=0. The latched flush then finds idx=0 and is discarded.

## Structure
- Shared package fifo_pkg holds:
  - DATA_W and LANES defaults.
  - State encoding: FILL=1'b0, OUT=1'b1.
  - Lane-index width $clog2(LANES).
- One sub-module, lane_reg: a per-lane byte register with write-enable and clear. Instantiated LANES times.
- FSM, counters and handshake stay in fifo_word_packer.

## Test plan
- Reset hold: reset_n=0 for 4 cycles with fifo_empty=0 -> fifo_get=0 and all outputs 0 throughout.
- Full word: FIFO holds 0x11,0x22,0x33,0x44 and word_ready=1 -> exactly 4 gets; word_data=0x44332211, word_be=4'hF, word_last=0, valid on cycle 5; words_out=1.
- Backpressure: 8 bytes 0x01..0x08 with word_ready=0 for 10 cycles -> word 0x04030201 held stable and no gets issued during the hold. After ready, the second word is 0x08070605; words_out=2.
- Flush: 3 bytes 0xAA,0xBB,0xCC then fifo_empty=1, then flush pulse -> word_data=0x00CCBBAA, word_be=4'h7, word_last=1.
- Edge cases:
  - Flush with idx=0 -> no word_valid.
  - Flush with a read in flight -> that byte is included.
- Mid-operation reset: reset_n=0 after 2 captured bytes -> outputs return to reset values. The next 4 bytes form a clean word with no stale lanes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-FIFO word packer.
// Default widths, FSM state encoding and lane-index width helper.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LANES_DEF  = 4;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    function automatic int lane_idx_w(input int lanes);
        return $clog2(lanes);
    endfunction

    localparam int IDX_W = lane_idx_w(LANES_DEF);

endpackage

// File: rtl/lane_reg.sv
// One byte lane of the packed output word.
// Ports: clk, reset_n (sync, active-low), clr, we, d -> q.
module lane_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs LANES bytes little-endian into a word.
// Ports: FIFO get/data/empty in, flush pulse, word valid/ready out.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int WCNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fifo_empty,
    input  logic [DATA_W-1:0]         fifo_data,
    output logic                      fifo_get,
    input  logic                      flush,
    output logic [DATA_W*LANES-1:0]   word_data,
    output logic [LANES-1:0]          word_be,
    output logic                      word_last,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [WCNT_W-1:0]         words_out
);

    localparam int IW = lane_idx_w(LANES);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL = CW'(LANES);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     issued_q;
    logic [CW-1:0]     idx_q;
    logic              pend_q;
    logic              flush_req_q;
    logic [LANES-1:0]  be_q;
    logic              last_q;
    logic [WCNT_W-1:0] cnt_q;

    logic              get;
    logic              cap;
    logic              full;
    logic              act;
    logic              flush_out;
    logic              accept;
    logic [CW-1:0]     idx_inc;
    logic [IW-1:0]     lane_sel;
    logic [LANES-1:0]  lane_we;

    // A flush is only acted on when no byte is in flight and none is
    // being requested this cycle, so no FIFO byte is ever dropped.
    // Reset gates the get so nothing is popped while held in reset.
    always_comb begin
        get = reset_n && (state_q == FILL) && !fifo_empty
              && (issued_q < FULL) && !flush_req_q;
        cap       = pend_q;
        idx_inc   = idx_q + CW'(1);
        full      = cap && (idx_inc == FULL);
        act       = (state_q == FILL) && !pend_q && !get
                    && (flush_req_q || flush);
        flush_out = act && (idx_q != '0);
        accept    = (state_q == OUT) && word_ready;
        lane_sel  = idx_q[IW-1:0];
        lane_we   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = cap && (lane_sel == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (full || flush_out) state_d = OUT;
            OUT:  if (word_ready)        state_d = FILL;
        endcase
    end

    always_comb begin
        fifo_get   = get;
        word_valid = (state_q == OUT);
        word_last  = last_q;
        word_be    = be_q;
        words_out  = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issued_q    <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            be_q        <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pend_q <= get;
            if (accept) begin
                issued_q    <= '0;
                idx_q       <= '0;
                be_q        <= '0;
                last_q      <= 1'b0;
                flush_req_q <= 1'b0;
                cnt_q       <= cnt_q + WCNT_W'(1);
            end else if (state_q == FILL) begin
                if (get) begin
                    issued_q <= issued_q + CW'(1);
                end
                if (cap) begin
                    idx_q <= idx_inc;
                    be_q  <= be_q | lane_we;
                end
                if (flush_out) begin
                    last_q <= 1'b1;
                end
                if (act) begin
                    flush_req_q <= 1'b0;
                end else if (flush) begin
                    flush_req_q <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_reg #(
            .W(DATA_W)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (accept),
            .we      (lane_we[i]),
            .d       (fifo_data),
            .q       (word_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer.
// Vector table, hand sequences, then random traffic vs a byte-stream model.
module tb_fifo_word_packer;
    import fifo_pkg::*;

    localparam int LN = 1 << IDX_W;
    localparam int DW = DATA_W_DEF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_get;
    logic          flush = 1'b0;
    logic [31:0]   word_data;
    logic [3:0]    word_be;
    logic          word_last;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [15:0]   words_out;

    fifo_word_packer #(
        .DATA_W(DW),
        .LANES (LN),
        .WCNT_W(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_get   (fifo_get),
        .flush      (flush),
        .word_data  (word_data),
        .word_be    (word_be),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    // Byte FIFO model: data appears the cycle after a sampled get.
    logic [7:0] fmem [0:4095];
    int         n_push = 0;
    int         n_pop  = 0;
    logic       stall  = 1'b0;

    assign fifo_empty = stall || (n_push == n_pop);

    always @(posedge clk) begin
        if (fifo_get) begin
            fifo_data <= fmem[n_pop % 4096];
            n_pop     <= n_pop + 1;
        end
    end

    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_words = 0;
    logic [7:0] sq [$];

    typedef struct {
        logic [31:0] bytes;
        int          n;
        bit          fl;
        logic [31:0] d;
        logic [3:0]  be;
        bit          last;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        fmem[n_push % 4096] = b;
        n_push++;
        sq.push_back(b);
    endtask

    task automatic wait_valid(input int lim, input string nm);
        int k = 0;
        while (!word_valid && k < lim) begin
            tick();
            k++;
        end
        if (!word_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: word_valid never rose", nm);
        end
    endtask

    task automatic accept_word(input string nm);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        exp_words++;
        chk({nm, "_count"}, words_out, 64'(exp_words[15:0]));
        chk({nm, "_drop"}, word_valid, 0);
    endtask

    task automatic check_word();
        int          n;
        logic [3:0]  m;
        logic [31:0] e;
        n = $countones(word_be);
        m = 4'((1 << n) - 1);
        chk("rnd_be_mask", word_be, m);
        if (!word_last) chk("rnd_full_be", n, 4);
        if (n > sq.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL rnd_underflow: got %0d bytes expected <= %0d",
                     n, sq.size());
        end else begin
            e = '0;
            for (int i = 0; i < n; i++) e[8*i +: 8] = sq[i];
            chk("rnd_data", word_data, e);
            for (int i = 0; i < n; i++) void'(sq.pop_front());
        end
        exp_words++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          p;
        logic        hold;
        logic [31:0] hd;
        logic [3:0]  hb;
        logic        hl;

        tv[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4'hF, 1'b0};
        tv[1] = '{32'h00CCBBAA, 3, 1'b1, 32'h00CCBBAA, 4'h7, 1'b1};
        tv[2] = '{32'h0000005A, 1, 1'b1, 32'h0000005A, 4'h1, 1'b1};
        tv[3] = '{32'h00009876, 2, 1'b1, 32'h00009876, 4'h3, 1'b1};
        tv[4] = '{32'hEFBEADDE, 4, 1'b0, 32'hEFBEADDE, 4'hF, 1'b0};
        tv[5] = '{32'h00FF0080, 3, 1'b1, 32'h00FF0080, 4'h7, 1'b1};

        // Reset hold with a non-empty FIFO.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (4) begin
            tick();
            chk("reset_hold",
                {fifo_get, word_valid, word_last, word_be, word_data,
                 words_out}, 0);
        end
        chk("reset_no_pop", n_pop, 0);

        // Full word latency.
        reset_n    = 1'b1;
        word_ready = 1'b1;
        p = n_pop;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("full_early_valid", word_valid, 0);
        end
        tick();
        chk("full_valid_c5", word_valid, 1);
        chk("full_data", word_data, 32'h44332211);
        chk("full_be", word_be, 4'hF);
        chk("full_last", word_last, 0);
        chk("full_gets", n_pop - p, 4);
        tick();
        word_ready = 1'b0;
        exp_words  = 1;
        chk("full_count", words_out, 1);
        chk("full_drop", word_valid, 0);

        // Backpressure.
        for (int b = 1; b <= 8; b++) push(8'(b));
        wait_valid(10, "bp_w1");
        chk("bp_w1_data", word_data, 32'h04030201);
        p = n_pop;
        repeat (10) begin
            tick();
            chk("bp_hold", {word_valid, word_be, word_last, word_data},
                {1'b1, 4'hF, 1'b0, 32'h04030201});
        end
        chk("bp_no_gets", n_pop - p, 0);
        accept_word("bp_w1");
        wait_valid(10, "bp_w2");
        chk("bp_w2_data", word_data, 32'h08070605);
        chk("bp_w2_be", word_be, 4'hF);
        accept_word("bp_w2");
        chk("bp_total", words_out, 3);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tv[v].n; i++) push(tv[v].bytes[8*i +: 8]);
            if (tv[v].fl) begin
                repeat (6) tick();
                chk("tv_pre_flush", word_valid, 0);
                flush = 1'b1;
                tick();
                flush = 1'b0;
                chk("tv_flush_1cyc", word_valid, 1);
            end else begin
                wait_valid(10, "tv_full");
            end
            chk("tv_data", word_data, tv[v].d);
            chk("tv_be", word_be, tv[v].be);
            chk("tv_last", word_last, tv[v].last);
            accept_word("tv");
        end

        // Flush with nothing captured.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) begin
            tick();
            chk("flush_idle_novalid", word_valid, 0);
        end
        push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
        wait_valid(10, "flush_idle_next");
        chk("flush_idle_next", {word_last, word_be, word_data},
            {1'b0, 4'hF, 32'h0D0C0B0A});
        accept_word("flush_idle");

        // Flush while a read is in flight.
        push(8'h10); push(8'h20);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flight_wait", word_valid, 0);
        tick();
        chk("flight_valid", word_valid, 1);
        chk("flight_word", {word_last, word_be, word_data},
            {1'b1, 4'h3, 32'h00002010});
        accept_word("flight");

        // Flush coinciding with the last byte's capture.
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("lastcap_valid", word_valid, 1);
        chk("lastcap_word", {word_last, word_be, word_data},
            {1'b0, 4'hF, 32'hA4A3A2A1});
        accept_word("lastcap");
        repeat (3) begin
            tick();
            chk("lastcap_discard", word_valid, 0);
        end
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        wait_valid(10, "lastcap_next");
        chk("lastcap_next", {word_last, word_be, word_data},
            {1'b0, 4'hF, 32'hB4B3B2B1});
        accept_word("lastcap_next");

        // Reset in the middle of a word.
        push(8'h55); push(8'h66);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_out",
            {fifo_get, word_valid, word_last, word_be, word_data,
             words_out}, 0);
        tick();
        reset_n   = 1'b1;
        exp_words = 0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid(10, "midrst_word");
        chk("midrst_word", {word_last, word_be, word_data},
            {1'b0, 4'hF, 32'h04030201});
        accept_word("midrst");

        // Random traffic against the byte-stream model.
        sq.delete();
        hold = 1'b0;
        hd = '0;
        hb = '0;
        hl = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush = 1'b0;
            chk("rnd_count", words_out, 64'(exp_words[15:0]));
            if (hold) begin
                chk("rnd_stable", {word_valid, word_be, word_last, word_data},
                    {1'b1, hb, hl, hd});
            end
            if (word_valid) chk("rnd_no_get_out", fifo_get, 0);
            word_ready = ($urandom_range(0, 3) != 0);
            if (word_valid && word_ready) check_word();
            hold = word_valid && !word_ready;
            hd   = word_data;
            hb   = word_be;
            hl   = word_last;
            if (cyc < 2500 && $urandom_range(0, 2) != 0) begin
                push(8'($urandom));
            end
            stall = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 24) == 0) flush = 1'b1;
            tick();
        end

        // Drain whatever is left with periodic flushes.
        stall = 1'b0;
        flush = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flush = 1'b0;
            word_ready = 1'b1;
            if (word_valid) check_word();
            if (cyc % 8 == 7) flush = 1'b1;
            tick();
            if (sq.size() == 0 && n_pop == n_push && !word_valid) break;
        end
        flush = 1'b0;
        word_ready = 1'b0;
        tick();
        chk("drain_left", sq.size(), 0);
        chk("drain_count", words_out, 64'(exp_words[15:0]));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
